// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory blocks: word size, default address
// width and the clear-sequencer state encoding.
package hack_mem_pkg;

    localparam int HACK_WORD      = 16;
    localparam int HACK_ADDR_BITS = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage : hack_mem_pkg

// File: rtl/ram_clr_seq.sv
// Clear sequencer: after reset it walks every address once, requesting a zero
// write per cycle, and holds busy high until the last word has been written.
module ram_clr_seq
    import hack_mem_pkg::*;
#(
    parameter int ADDR_BITS      = HACK_ADDR_BITS,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 busy_o,
    output logic                 clr_we_o,
    output logic [ADDR_BITS-1:0] clr_addr_o
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    clr_state_e           state_q;
    logic [ADDR_BITS-1:0] clr_ptr_q;
    logic                 busy_q;

    // Clear FSM; termination is by compare with the last address, not by wrap
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clr_ptr_q <= {ADDR_BITS{1'b0}};
            if (CLEAR_ON_RESET != 0) begin
                state_q <= CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_ONE;
                    if (clr_ptr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                IDLE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q & ~reset_i;
    assign clr_addr_o = clr_ptr_q;

endmodule : ram_clr_seq

// File: rtl/ram_dp_clr.sv
// Hack RAM with legacy write/async-read port A, a registered read port B and a
// post-reset hardware clear that locks both ports out while it runs.
module ram_dp_clr
    import hack_mem_pkg::*;
#(
    parameter int WIDTH          = HACK_WORD,
    parameter int ADDR_BITS      = HACK_ADDR_BITS,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 load,
    output logic [WIDTH-1:0]     out,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 seq_busy;
    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH-1:0]     rd_data_q;
    logic [WIDTH-1:0]     rd_data_d;
    logic                 rd_valid_q;
    logic                 rd_valid_d;

    ram_clr_seq #(
        .ADDR_BITS      (ADDR_BITS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_seq (
        .clk_i      (clk),
        .reset_i    (reset),
        .busy_o     (seq_busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Write-path mux: the clear engine owns the array while busy
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = in;
        if (reset) begin
            wr_en = 1'b0;
        end else if (seq_busy) begin
            wr_en   = clr_we;
            wr_addr = clr_addr;
            wr_data = {WIDTH{1'b0}};
        end else begin
            wr_en = load;
        end
    end

    // Storage array, no reset: contents survive unless the clear engine runs
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Port B next state; a same-edge write to the read address is forwarded
    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (reset) begin
            rd_valid_d = 1'b0;
            rd_data_d  = {WIDTH{1'b0}};
        end else if (seq_busy) begin
            rd_valid_d = 1'b0;
        end else if (rd_en) begin
            rd_valid_d = 1'b1;
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_addr];
            end
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Port B output registers
    always_ff @(posedge clk) begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
    end

    assign out      = seq_busy ? {WIDTH{1'b0}} : mem_q[addr];
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = seq_busy;

endmodule : ram_dp_clr

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: one instance that clears on reset and one that
// does not, driven through a linear sequence of hand-checked steps.
module tb_ram_dp_clr;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic [3:0]  addr;
    logic        load;
    logic [15:0] dout;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;

    logic        reset_nc;
    logic [15:0] din_nc;
    logic [3:0]  addr_nc;
    logic        load_nc;
    logic [15:0] dout_nc;
    logic [3:0]  rd_addr_nc;
    logic        rd_en_nc;
    logic [15:0] rd_data_nc;
    logic        rd_valid_nc;
    logic        busy_nc;

    int n_assert;
    int n_fail;
    int cnt;

    ram_dp_clr #(.WIDTH(16), .ADDR_BITS(4), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .reset(reset), .in(din), .addr(addr), .load(load), .out(dout),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy)
    );

    ram_dp_clr #(.WIDTH(16), .ADDR_BITS(4), .CLEAR_ON_RESET(0)) u_dut_nc (
        .clk(clk), .reset(reset_nc), .in(din_nc), .addr(addr_nc), .load(load_nc),
        .out(dout_nc), .rd_addr(rd_addr_nc), .rd_en(rd_en_nc), .rd_data(rd_data_nc),
        .rd_valid(rd_valid_nc), .busy(busy_nc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(input string tag);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk(tag, 32'(cnt), 32'd16);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1; din = 16'h0000; addr = 4'd0; load = 1'b0;
        rd_addr = 4'd0; rd_en = 1'b0;
        reset_nc = 1'b1; din_nc = 16'h0000; addr_nc = 4'd0; load_nc = 1'b0;
        rd_addr_nc = 4'd0; rd_en_nc = 1'b0;

        // Reset state
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_out", 32'(dout), 32'd0);
        chk("rst_busy_nc", 32'(busy_nc), 32'd0);

        // Busy lockout during the initial clear, plus busy length
        reset = 1'b0; reset_nc = 1'b0;
        load = 1'b1; addr = 4'd5; din = 16'h1234; rd_en = 1'b1; rd_addr = 4'd5;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
            chk("lock_out", 32'(dout), 32'd0);
            chk("lock_rd_valid", 32'(rd_valid), 32'd0);
        end
        chk("init_busy_edges", 32'(cnt), 32'd16);
        load = 1'b0; rd_en = 1'b0;
        #1;
        chk("lock_mem5", 32'(dout), 32'd0);

        // Legacy port A: write i*2, visible right after the write edge
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i); din = 16'(i * 2); load = 1'b1;
            step();
            chk("legacy_wr", 32'(dout), 32'(i * 2));
        end
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk("legacy_rd", 32'(dout), 32'(i * 2));
        end

        // Port B plain read of legacy data
        rd_en = 1'b1; rd_addr = 4'd10;
        step();
        chk("pb_legacy", 32'(rd_data), 32'h14);
        rd_en = 1'b0;

        // Port B latency
        addr = 4'd3; din = 16'hA5A5; load = 1'b1;
        step();
        load = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
        step();
        chk("pb_valid", 32'(rd_valid), 32'd1);
        chk("pb_data", 32'(rd_data), 32'hA5A5);
        rd_en = 1'b0;
        step();
        chk("pb_valid_drop", 32'(rd_valid), 32'd0);
        chk("pb_data_hold", 32'(rd_data), 32'hA5A5);

        // Collision: write-first
        addr = 4'd7; din = 16'h0001; load = 1'b1;
        step();
        din = 16'h00FF; rd_en = 1'b1; rd_addr = 4'd7;
        step();
        chk("coll_data", 32'(rd_data), 32'h00FF);
        chk("coll_valid", 32'(rd_valid), 32'd1);
        chk("coll_out", 32'(dout), 32'h00FF);
        load = 1'b0; rd_en = 1'b0;
        step();

        // Clear after reset
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i); din = 16'hBEEF; load = 1'b1;
            step();
        end
        load = 1'b0;
        addr = 4'd9;
        #1;
        chk("fill_beef", 32'(dout), 32'hBEEF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("clr_busy_start", 32'(busy), 32'd1);
        count_busy("clr_busy_edges");
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i); rd_addr = 4'(i); rd_en = 1'b1;
            step();
            chk("clr_out", 32'(dout), 32'd0);
            chk("clr_rd_data", 32'(rd_data), 32'd0);
            chk("clr_rd_valid", 32'(rd_valid), 32'd1);
        end
        rd_en = 1'b0;

        // Reset mid-clear at clr_ptr=7, held two cycles
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i); din = 16'hBEEF; load = 1'b1;
            step();
        end
        load = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("mid_busy_held", 32'(busy), 32'd1);
        count_busy("mid_busy_edges");
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk("mid_out", 32'(dout), 32'd0);
        end

        // CLEAR_ON_RESET=0: data preserved, busy never rises, no write in reset
        addr_nc = 4'd2; din_nc = 16'hCAFE; load_nc = 1'b1;
        step();
        addr_nc = 4'd9; din_nc = 16'h1357;
        step();
        addr_nc = 4'd4; din_nc = 16'h4444;
        step();
        rd_en_nc = 1'b1; rd_addr_nc = 4'd2;
        din_nc = 16'hDEAD;
        reset_nc = 1'b1;
        step();
        chk("nc_rst_busy", 32'(busy_nc), 32'd0);
        chk("nc_rst_rd_valid", 32'(rd_valid_nc), 32'd0);
        chk("nc_rst_rd_data", 32'(rd_data_nc), 32'd0);
        reset_nc = 1'b0; load_nc = 1'b0; rd_en_nc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nc_busy_low", 32'(busy_nc), 32'd0);
        end
        addr_nc = 4'd2;
        #1;
        chk("nc_keep2", 32'(dout_nc), 32'hCAFE);
        addr_nc = 4'd4;
        #1;
        chk("nc_no_wr_in_reset", 32'(dout_nc), 32'h4444);
        rd_en_nc = 1'b1; rd_addr_nc = 4'd9;
        step();
        chk("nc_pb_data", 32'(rd_data_nc), 32'h1357);
        chk("nc_pb_valid", 32'(rd_valid_nc), 32'd1);
        rd_en_nc = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_ram_dp_clr

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
Parametrised successor to the single-port Hack `ram` block. It keeps the legacy write/asynchronous-read port and adds:
- a second, registered read-only port, for the screen/refresh reader;
- a hardware clear engine that zeroes every word after reset and reports `busy` while it runs.

It sits in the Hack memory map wherever RAM/screen storage is instantiated.

Parameters:
WIDTH, 16, data word width in bits
ADDR_BITS, 4, address width; DEPTH = 2**ADDR_BITS words
CLEAR_ON_RESET, 1, 1 = run the zeroing sequence after reset; 0 = reset touches control state only, memory is left as is

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in  input  WIDTH  port A write data
addr  input  ADDR_BITS  port A address (write and read)
load  input  1  port A write enable; mem[addr] <= in at the rising edge
out  output  WIDTH  port A combinational read of mem[addr]
rd_addr  input  ADDR_BITS  port B read address
rd_en  input  1  port B read request
rd_data  output  WIDTH  port B registered read data
rd_valid  output  1  rd_data holds the result of the request made in the previous cycle
busy  output  1  clear sequence in progress

Behaviour:
- FSM states: IDLE, CLEAR. The clear pointer `clr_ptr` is ADDR_BITS wide.
- Reset (reset=1 at an edge):
  - CLEAR_ON_RESET=1: state <= CLEAR, clr_ptr <= 0, busy <= 1.
  - CLEAR_ON_RESET=0: state <= IDLE, busy <= 0.
  - In both modes: rd_data <= 0, rd_valid <= 0.
  - While reset is held, clr_ptr stays 0 and no memory writes occur.
- CLEAR (reset=0), each edge:
  - mem[clr_ptr] <= 0, then clr_ptr <= clr_ptr+1.
  - On the edge that writes DEPTH-1: state <= IDLE, busy <= 0.
  - busy is therefore high for exactly DEPTH edges after reset is released.
- Port behaviour while busy=1:
  - load is ignored; no port A write occurs.
  - out is forced to 0.
  - rd_en is ignored; rd_valid <= 0.
- Reset asserted mid-clear: the sequence restarts from clr_ptr=0 and takes a full DEPTH cycles after release.
- Port A in IDLE keeps legacy semantics:
  - Write when load=1.
  - out = mem[addr] combinationally, so after a write edge out shows the new value with no extra latency.
- Port B in IDLE:
  - rd_en=1 at edge N gives rd_data = mem[rd_addr] and rd_valid=1 after edge N (1-cycle latency).
  - rd_en=0 gives rd_valid <= 0 and rd_data holds its last value.
- Collision (port A write and port B read to the same address on the same edge): write-first. rd_data returns the newly written `in`.
- Addresses wrap naturally at ADDR_BITS; there is no out-of-range condition.
- No arithmetic beyond the clr_ptr increment. The increment wraps; termination is decided by comparison with DEPTH-1, not by overflow.

Decomposition:
- Shared package `hack_mem_pkg`:
  - state enum {IDLE, CLEAR};
  - constants HACK_WORD=16 and default ADDR_BITS.
- One natural sub-module, `ram_clr_seq`:
  - contains the FSM plus clr_ptr;
  - outputs busy, clr_we and clr_addr;
  - the top level muxes the write path: clear when busy, else port A.
- The storage array and port B register stay in the top level.

Test Plan:
- Legacy compatibility (WIDTH=16, ADDR_BITS=4, after clear completes):
  - write in=i*2 to addr i with load=1 for i=0..15, then read each back with load=0;
  - out == i*2 on every read;
  - out shows the new value one edge after each write.
- Clear after reset:
  - fill all 16 words with 16'hBEEF, then pulse reset for 1 cycle;
  - busy is high for exactly 16 edges, then 0;
  - every address then reads 16'h0000 on both ports.
- Busy lockout:
  - during clear, drive load=1, addr=5, in=16'h1234 and rd_en=1;
  - out == 0 and rd_valid == 0 throughout;
  - after busy falls, mem[5] == 0.
- Port B latency:
  - write 16'hA5A5 to addr 3, then rd_en=1, rd_addr=3 for one cycle;
  - rd_valid=1 and rd_data=16'hA5A5 on the next cycle;
  - rd_valid returns to 0 the cycle after.
- Collision:
  - mem[7]=16'h0001; on the same edge drive load=1, addr=7, in=16'h00FF and rd_en=1, rd_addr=7;
  - rd_data=16'h00FF.
- Reset mid-clear:
  - assert reset when clr_ptr=7, hold it 2 cycles, then release;
  - busy stays high for a further 16 edges and all words read 0;
  - with CLEAR_ON_RESET=0, busy never rises and previously written data is preserved.
